sync_fifo_flags: RTL
====================

// Module: sync_fifo_flags
// PURPOSE
//  Parametrised single-clock FIFO with registered read port, full/empty and
//  programmable almost-full/almost-empty flags, occupancy count and sticky
//  overflow/underflow errors. Generalises the fixed 8x9 buffer to any width and
//  power-of-two depth. Sits between a producer and a consumer in one clock domain.
// PARAMETERS
//  DATA_W    9   data word width in bits
//  DEPTH     8   number of entries; power of two, >= 2
//  AF_LEVEL  6   almost_full asserts when count >= AF_LEVEL
//  AE_LEVEL  2   almost_empty asserts when count <= AE_LEVEL
//  ADDR_W    $clog2(DEPTH)  derived; do not override
// PORTS
//  clk          in   1         clock, all logic on rising edge
//  rst          in   1         asynchronous active-high reset
//  clr          in   1         synchronous flush of pointers, count and errors
//  wr_en        in   1         write request
//  wr_data      in   DATA_W    write data
//  rd_en        in   1         read request
//  rd_data      out  DATA_W    read data, registered
//  rd_valid     out  1         rd_data holds a newly read word this cycle
//  full         out  1         count == DEPTH
//  empty        out  1         count == 0
//  almost_full  out  1         count >= AF_LEVEL
//  almost_empty out  1         count <= AE_LEVEL
//  count        out  ADDR_W+1  occupancy, 0..DEPTH
//  overflow     out  1         sticky: write rejected while full
//  underflow    out  1         sticky: read rejected while empty
// BEHAVIOUR
//  - Reset (async assert, sync deassert at the system level): pointers = 0,
//    count = 0, rd_data = 0, rd_valid = 0, overflow = underflow = 0, empty = 1,
//    almost_empty = 1, full = almost_full = 0. Memory contents are not reset.
//  - wr_acc = wr_en & (~full | rd_acc). rd_acc = rd_en & ~empty.
//  - A write to a full FIFO is accepted only when a read is accepted in the same cycle.
//  - A read from an empty FIFO is never accepted. There is no write-to-read bypass.
//  - Accepted write: mem[wr_ptr] <= wr_data; wr_ptr advances, wrapping DEPTH-1 -> 0.
//  - Accepted read: rd_data <= mem[rd_ptr] at the next edge, with rd_valid = 1 for
//    that one cycle. Latency from rd_en to data is 1 cycle. rd_ptr wraps like wr_ptr.
//  - If no read is accepted, rd_data holds its last value (never Z) and rd_valid = 0.
//  - count: +1 on write only, -1 on read only, unchanged when both or neither occur.
//  - All flags are decoded combinationally from the registered count, so they are
//    valid in the cycle after the event that changed count.
//  - overflow sets when wr_en & full & ~rd_acc. underflow sets when rd_en & empty.
//    Both hold until rst or clr.
//  - clr has priority over wr_en and rd_en in the same cycle. It zeroes the pointers,
//    count and errors and drives rd_valid to 0. rd_data and memory are untouched.
//  - rst asserted mid-operation immediately forces the reset values above.
//    Data already in the FIFO is lost.
// STRUCTURE
//  - fifo_pkg: width helper function (clog2) and common flag-level constants shared
//    with future async FIFO variants.
//  - Sub-module fifo_mem_2p: simple dual-port RAM, DATA_W x DEPTH, with a
//    synchronous write port and a synchronous read port with enable.
//  - Top level holds the pointers, count, flag decode and error logic.
// TESTING
//  - Reset: assert rst mid-stream -> count=0, empty=1, almost_empty=1, rd_valid=0,
//    errors=0, all with no clock edge.
//  - Fill: 8 writes of 0x101..0x108 -> count steps 1..8. almost_full rises at count 6,
//    full at 8. A 9th write -> overflow=1, count stays 8.
//  - Drain: 8 reads -> rd_data = 0x101..0x108 in order, one cycle after each rd_en,
//    rd_valid=1 each. A 9th read -> underflow=1, rd_valid=0, rd_data holds 0x108.
//  - Simultaneous: full FIFO, wr_en=rd_en=1 with 0x1AA -> count stays 8, no overflow.
//    0x1AA emerges after 7 further reads.
//  - Wrap: 20 interleaved writes/reads at count 3 -> data order preserved across
//    pointer wrap, count constant.
//  - clr with wr_en=1 on a half-full FIFO -> count=0, empty=1, errors cleared,
//    write discarded.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and flag levels, the access-kind
// encoding used by occupancy tracking, and an address-width helper.
package fifo_pkg;

    localparam int FIFO_DEF_DATA_W   = 9;
    localparam int FIFO_DEF_DEPTH    = 8;
    localparam int FIFO_DEF_AF_LEVEL = 6;
    localparam int FIFO_DEF_AE_LEVEL = 2;

    // {write accepted, read accepted} packed into one code
    typedef enum logic [1:0] {
        ACC_NONE = 2'b00,
        ACC_RD   = 2'b01,
        ACC_WR   = 2'b10,
        ACC_BOTH = 2'b11
    } fifo_acc_e;

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port RAM: synchronous write port, registered read port with
// enable. Storage is never reset; only the read register is.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DEF_DATA_W,
    parameter int DEPTH  = FIFO_DEF_DEPTH,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Write port: store the word at the write address
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port: capture the addressed word on enable, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered read data, occupancy count, full/empty and
// programmable almost-full/almost-empty flags, and sticky overflow/underflow.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_W   = FIFO_DEF_DATA_W,
    parameter int DEPTH    = FIFO_DEF_DEPTH,
    parameter int AF_LEVEL = FIFO_DEF_AF_LEVEL,
    parameter int AE_LEVEL = FIFO_DEF_AE_LEVEL,
    parameter int ADDR_W   = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0]   CNT_DEPTH = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_AF    = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_AE    = AE_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              rd_valid_q, rd_valid_d;

    logic              wr_acc, rd_acc;
    logic              mem_we, mem_re;
    fifo_acc_e         acc;

    // Flags decode straight from the registered occupancy
    assign full         = (count_q == CNT_DEPTH);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);

    // A full FIFO still takes a write when a read frees a slot in the same cycle
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    // Flush wins over any access, so nothing reaches the RAM during clr
    assign mem_we = wr_acc & ~clr;
    assign mem_re = rd_acc & ~clr;
    assign acc    = fifo_acc_e'({mem_we, mem_re});

    // Next-state for pointers, occupancy, read-valid and sticky errors
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        rd_valid_d = 1'b0;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (mem_we) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (mem_re) rd_ptr_d = rd_ptr_q + PTR_ONE;
            rd_valid_d = mem_re;
            unique case (acc)
                ACC_WR:  count_d = count_q + CNT_ONE;
                ACC_RD:  count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (wr_en & full & ~rd_acc) ovf_d = 1'b1;
            if (rd_en & empty)          unf_d = 1'b1;
        end
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (mem_re),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
